// File: rtl/lcd_bus_decoder_if.sv
// 8080-style display write bus plus the decoder's event/status outputs.
interface lcd_bus_decoder_if #(
  parameter int unsigned COORD_W = 9
);
  logic               wr;
  logic               dcx;
  logic [7:0]         D;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [15:0]        pix_color;
  logic               cmd_valid;
  logic [7:0]         cmd_code;
  logic               frame_done;
  logic               disp_on;
  logic               sleep_out;

  modport master (
    output wr, dcx, D,
    input  pix_valid, pix_x, pix_y, pix_color, cmd_valid, cmd_code, frame_done, disp_on, sleep_out
  );

  modport slave (
    input  wr, dcx, D,
    output pix_valid, pix_x, pix_y, pix_color, cmd_valid, cmd_code, frame_done, disp_on, sleep_out
  );
endinterface

// File: rtl/lcd_bus_decoder.sv
// Display-side receiver: decodes commands, tracks the CASET/RASET window and
// turns RAMWR RGB565 byte pairs into pixel events with cursor coordinates.
module lcd_bus_decoder #(
  parameter int unsigned COORD_W = 9,
  parameter int unsigned X_MAX   = 239,
  parameter int unsigned Y_MAX   = 319
) (
  input logic clk,
  input logic nrst,
  lcd_bus_decoder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCaset, StRaset, StRamwr} state_e;

  localparam logic [COORD_W-1:0] XeRst = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YeRst = COORD_W'(Y_MAX);

  state_e             r_state, w_state_nxt;
  logic               r_wr_q;
  logic [1:0]         r_pidx, w_pidx_nxt;
  logic [7:0]         r_hi, w_hi_nxt;
  logic [COORD_W-1:0] r_sh_s, w_sh_s_nxt;
  logic [COORD_W-1:0] r_xs, w_xs_nxt, r_xe, w_xe_nxt;
  logic [COORD_W-1:0] r_ys, w_ys_nxt, r_ye, w_ye_nxt;
  logic [COORD_W-1:0] r_cx, w_cx_nxt, r_cy, w_cy_nxt;
  logic               r_phase, w_phase_nxt;
  logic               r_pix_valid, w_pix_valid_nxt;
  logic [COORD_W-1:0] r_pix_x, w_pix_x_nxt, r_pix_y, w_pix_y_nxt;
  logic [15:0]        r_pix_color, w_pix_color_nxt;
  logic               r_cmd_valid, w_cmd_valid_nxt;
  logic [7:0]         r_cmd_code, w_cmd_code_nxt;
  logic               r_frame_done, w_frame_done_nxt;
  logic               r_disp_on, w_disp_on_nxt;
  logic               r_sleep_out, w_sleep_out_nxt;
  logic               w_evt;
  logic [COORD_W-1:0] w_val;

  assign w_evt = bus.wr & ~r_wr_q;
  assign w_val = COORD_W'({r_hi, bus.D});

  always_comb begin
    w_state_nxt      = r_state;
    w_pidx_nxt       = r_pidx;
    w_hi_nxt         = r_hi;
    w_sh_s_nxt       = r_sh_s;
    w_xs_nxt         = r_xs;
    w_xe_nxt         = r_xe;
    w_ys_nxt         = r_ys;
    w_ye_nxt         = r_ye;
    w_cx_nxt         = r_cx;
    w_cy_nxt         = r_cy;
    w_phase_nxt      = r_phase;
    w_pix_valid_nxt  = 1'b0;
    w_pix_x_nxt      = r_pix_x;
    w_pix_y_nxt      = r_pix_y;
    w_pix_color_nxt  = r_pix_color;
    w_cmd_valid_nxt  = 1'b0;
    w_cmd_code_nxt   = r_cmd_code;
    w_frame_done_nxt = 1'b0;
    w_disp_on_nxt    = r_disp_on;
    w_sleep_out_nxt  = r_sleep_out;

    if (w_evt && !bus.dcx) begin
      // A command always abandons any partial parameter list or pixel.
      w_cmd_valid_nxt = 1'b1;
      w_cmd_code_nxt  = bus.D;
      w_state_nxt     = StIdle;
      w_pidx_nxt      = 2'd0;
      w_phase_nxt     = 1'b0;
      case (bus.D)
        8'h2A: w_state_nxt = StCaset;
        8'h2B: w_state_nxt = StRaset;
        8'h2C: begin
          w_state_nxt = StRamwr;
          w_cx_nxt    = r_xs;
          w_cy_nxt    = r_ys;
        end
        8'h01: begin
          w_xs_nxt        = '0;
          w_xe_nxt        = XeRst;
          w_ys_nxt        = '0;
          w_ye_nxt        = YeRst;
          w_disp_on_nxt   = 1'b0;
          w_sleep_out_nxt = 1'b0;
        end
        8'h11:   w_sleep_out_nxt = 1'b1;
        8'h10:   w_sleep_out_nxt = 1'b0;
        8'h29:   w_disp_on_nxt   = 1'b1;
        8'h28:   w_disp_on_nxt   = 1'b0;
        default: ;
      endcase
    end else if (w_evt) begin
      case (r_state)
        StCaset, StRaset: begin
          w_pidx_nxt = r_pidx + 2'd1;
          case (r_pidx)
            2'd0: w_hi_nxt   = bus.D;
            2'd1: w_sh_s_nxt = w_val;
            2'd2: w_hi_nxt   = bus.D;
            2'd3: begin
              if (r_state == StCaset) begin
                w_xs_nxt = r_sh_s;
                w_xe_nxt = w_val;
              end else begin
                w_ys_nxt = r_sh_s;
                w_ye_nxt = w_val;
              end
              w_state_nxt = StIdle;
            end
          endcase
        end
        StRamwr: begin
          if (!r_phase) begin
            w_hi_nxt    = bus.D;
            w_phase_nxt = 1'b1;
          end else begin
            w_phase_nxt     = 1'b0;
            w_pix_valid_nxt = 1'b1;
            w_pix_x_nxt     = r_cx;
            w_pix_y_nxt     = r_cy;
            w_pix_color_nxt = {r_hi, bus.D};
            // >= rather than == so a degenerate window (start > end) wraps every pixel.
            if (r_cx >= r_xe) begin
              w_cx_nxt = r_xs;
              if (r_cy >= r_ye) begin
                w_cy_nxt         = r_ys;
                w_frame_done_nxt = 1'b1;
              end else begin
                w_cy_nxt = r_cy + 1'b1;
              end
            end else begin
              w_cx_nxt = r_cx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= StIdle;
      r_wr_q       <= 1'b0;
      r_pidx       <= 2'd0;
      r_hi         <= 8'h00;
      r_sh_s       <= '0;
      r_xs         <= '0;
      r_xe         <= XeRst;
      r_ys         <= '0;
      r_ye         <= YeRst;
      r_cx         <= '0;
      r_cy         <= '0;
      r_phase      <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_color  <= 16'h0000;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= 8'h00;
      r_frame_done <= 1'b0;
      r_disp_on    <= 1'b0;
      r_sleep_out  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_q       <= bus.wr;
      r_pidx       <= w_pidx_nxt;
      r_hi         <= w_hi_nxt;
      r_sh_s       <= w_sh_s_nxt;
      r_xs         <= w_xs_nxt;
      r_xe         <= w_xe_nxt;
      r_ys         <= w_ys_nxt;
      r_ye         <= w_ye_nxt;
      r_cx         <= w_cx_nxt;
      r_cy         <= w_cy_nxt;
      r_phase      <= w_phase_nxt;
      r_pix_valid  <= w_pix_valid_nxt;
      r_pix_x      <= w_pix_x_nxt;
      r_pix_y      <= w_pix_y_nxt;
      r_pix_color  <= w_pix_color_nxt;
      r_cmd_valid  <= w_cmd_valid_nxt;
      r_cmd_code   <= w_cmd_code_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_disp_on    <= w_disp_on_nxt;
      r_sleep_out  <= w_sleep_out_nxt;
    end
  end

  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_x      = r_pix_x;
  assign bus.pix_y      = r_pix_y;
  assign bus.pix_color  = r_pix_color;
  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.cmd_code   = r_cmd_code;
  assign bus.frame_done = r_frame_done;
  assign bus.disp_on    = r_disp_on;
  assign bus.sleep_out  = r_sleep_out;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Scoreboard bench for lcd_bus_decoder: directed bus traffic, expected pixels and
// commands queued at issue time, checked by an independent negedge monitor.
module tb_lcd_bus_decoder;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] c;
    logic        fd;
  } pix_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_pix_seen = 0;
  pix_t       q_pix[$];
  logic [7:0] q_cmd[$];

  lcd_bus_decoder_if #(.COORD_W(9)) bus ();

  lcd_bus_decoder #(
    .COORD_W(9),
    .X_MAX  (239),
    .Y_MAX  (319)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic c, input logic [7:0] d);
    @(negedge clk);
    bus.wr  = 1'b1;
    bus.dcx = c;
    bus.D   = d;
    if (!c) q_cmd.push_back(d);
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic exp_pix(input int x, input int y, input logic [15:0] c, input logic fd);
    pix_t p;
    p.x  = 9'(x);
    p.y  = 9'(y);
    p.c  = c;
    p.fd = fd;
    q_pix.push_back(p);
  endtask

  task automatic send_pix(input logic [15:0] c);
    send(1'b1, c[15:8]);
    send(1'b1, c[7:0]);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    if (nrst) begin
      if (bus.pix_valid) begin
        n_pix_seen++;
        if (q_pix.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", bus.pix_x, bus.pix_y);
        end else begin
          pix_t e;
          e = q_pix.pop_front();
          chk("pix_x", 32'(bus.pix_x), 32'(e.x));
          chk("pix_y", 32'(bus.pix_y), 32'(e.y));
          chk("pix_color", 32'(bus.pix_color), 32'(e.c));
          chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
        end
      end else if (bus.frame_done) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_done_without_pixel: got 1 expected 0");
      end
      if (bus.cmd_valid) begin
        if (q_cmd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_cmd: got %0h expected none", bus.cmd_code);
        end else begin
          logic [7:0] ec;
          ec = q_cmd.pop_front();
          chk("cmd_code", 32'(bus.cmd_code), 32'(ec));
        end
      end
    end
  end

  initial begin
    int cnt;
    int seen;
    bus.wr  = 1'b0;
    bus.dcx = 1'b0;
    bus.D   = 8'h00;

    // Reset values
    #12;
    chk("rst_pix_valid", 32'(bus.pix_valid), 0);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("rst_cmd_code", 32'(bus.cmd_code), 0);
    chk("rst_disp_on", 32'(bus.disp_on), 0);
    chk("rst_sleep_out", 32'(bus.sleep_out), 0);
    @(negedge clk);
    nrst = 1'b1;

    // 1: sleep out, display on
    send(1'b0, 8'h11);
    chk("sleep_out_set", 32'(bus.sleep_out), 1);
    send(1'b0, 8'h29);
    chk("disp_on_set", 32'(bus.disp_on), 1);

    // 2: 3x2 window at (10..12, 5..6), two full frames
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h0A); send(1'b1, 8'h00); send(1'b1, 8'h0C);
    send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h06);
    send(1'b0, 8'h2C);
    for (int f = 0; f < 2; f++) begin
      exp_pix(10, 5, 16'hF800, 1'b0); exp_pix(11, 5, 16'hF800, 1'b0);
      exp_pix(12, 5, 16'hF800, 1'b0); exp_pix(10, 6, 16'hF800, 1'b0);
      exp_pix(11, 6, 16'hF800, 1'b0); exp_pix(12, 6, 16'hF800, 1'b1);
    end
    for (int i = 0; i < 12; i++) send_pix(16'hF800);

    // 3: latency and held-high strobe; cursor has wrapped back to (10,5)
    send(1'b1, 8'h07);
    exp_pix(10, 5, 16'h07E0, 1'b0);
    @(negedge clk);
    bus.wr  = 1'b1;
    bus.dcx = 1'b1;
    bus.D   = 8'hE0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("latency_first_cycle", 32'(bus.pix_valid), 1);
      if (bus.pix_valid) cnt++;
    end
    bus.wr = 1'b0;
    chk("held_wr_single_event", 32'(cnt), 1);

    // 4: partial pixel dropped by a new RAMWR
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    send(1'b0, 8'h2C);
    exp_pix(10, 5, 16'h1234, 1'b0);
    send(1'b1, 8'h12); send(1'b1, 8'h34);

    // 6a: SWRESET restores window and clears status
    send(1'b0, 8'h01);
    chk("swreset_disp_on", 32'(bus.disp_on), 0);
    chk("swreset_sleep_out", 32'(bus.sleep_out), 0);

    // 5: truncated CASET leaves the full-width window, row wraps after 240
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h10); send(1'b1, 8'h00);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 241; i++) begin
      exp_pix(i % 240, i / 240, 16'(i * 3 + 1), 1'b0);
      send_pix(16'(i * 3 + 1));
    end

    // Degenerate column window (xs > xe) with a 2-row window
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h03);
    send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h01);
    send(1'b0, 8'h2C);
    exp_pix(5, 0, 16'hAAAA, 1'b0);
    exp_pix(5, 1, 16'hBBBB, 1'b1);
    exp_pix(5, 0, 16'hCCCC, 1'b0);
    send_pix(16'hAAAA); send_pix(16'hBBBB); send_pix(16'hCCCC);

    // 6b: async reset mid-RAMWR, no clock edge before the check
    send(1'b0, 8'h29);
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    #2 nrst = 1'b0;
    #1;
    chk("async_pix_x", 32'(bus.pix_x), 0);
    chk("async_pix_color", 32'(bus.pix_color), 0);
    chk("async_cmd_code", 32'(bus.cmd_code), 0);
    chk("async_disp_on", 32'(bus.disp_on), 0);
    @(negedge clk);
    nrst = 1'b1;
    seen = n_pix_seen;
    send(1'b1, 8'hCD);
    send(1'b1, 8'hEF);
    chk("post_reset_data_ignored", 32'(n_pix_seen - seen), 0);

    repeat (3) @(negedge clk);
    chk("pix_queue_drained", 32'(q_pix.size()), 0);
    chk("cmd_queue_drained", 32'(q_cmd.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_decoder.md
Name: lcd_bus_decoder

Overview:
- Display-side receiver for the 8-bit 8080-style write bus (wr, dcx, D) that the image generator drives.
- Decodes command and parameter bytes and tracks the column/row address window (CASET/RASET).
- Turns RAMWR RGB565 byte pairs into pixel-write events with x/y coordinates.
- Serves as the on-chip display model for frame checking and as a scoreboard source in system benches.

Parameters:
- COORD_W, 9, width of the coordinate outputs and the window registers.
- X_MAX, 239, reset value of the window end column.
- Y_MAX, 319, reset value of the window end row.

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- wr  input  1  write strobe, synchronous to clk; a byte is latched on its rising edge.
- dcx  input  1  0 = command byte, 1 = parameter/data byte.
- D  input  8  bus byte.
- pix_valid  output  1  one-cycle pulse per complete pixel.
- pix_x  output  COORD_W  column of the emitted pixel.
- pix_y  output  COORD_W  row of the emitted pixel.
- pix_color  output  16  RGB565 value: first byte is [15:8], second byte is [7:0].
- cmd_valid  output  1  one-cycle pulse per command byte received.
- cmd_code  output  8  last command byte.
- frame_done  output  1  one-cycle pulse when the pixel at (xe, ye) is written.
- disp_on  output  1  display-on state.
- sleep_out  output  1  sleep-out state.

Behaviour:
- Reset (async, nrst=0):
  - All pulses 0; pix_x, pix_y, pix_color, cmd_code are 0; disp_on and sleep_out are 0.
  - Window: xs=0, xe=X_MAX, ys=0, ye=Y_MAX. State is IDLE. wr_q=0.
- Edge detect:
  - wr_q is wr registered.
  - A byte event occurs in the cycle where wr=1 and wr_q=0; D and dcx are sampled in that cycle.
  - Held-high wr produces no further events.
- Latency: every output pulse asserts the cycle after the byte event and lasts exactly 1 cycle.
- Command byte (dcx=0):
  - Always pulses cmd_valid and updates cmd_code.
  - Any partial parameter or pixel in progress is discarded.
  - The next state is chosen by the byte value:
    - 0x2A goes to CASET with param index 0.
    - 0x2B goes to RASET with param index 0.
    - 0x2C goes to RAMWR, loads cursor x=xs, y=ys, and clears the byte phase.
    - 0x01 (SWRESET) restores the reset window, clears disp_on and sleep_out, and goes to IDLE.
    - 0x11 sets sleep_out. 0x10 clears sleep_out. 0x29 sets disp_on. 0x28 clears disp_on. Each then goes to IDLE.
    - Any other value goes to IDLE.
- Data byte (dcx=1), by state:
  - IDLE: byte ignored.
  - CASET / RASET:
    - Bytes 0..3 fill a shadow register in order start_hi, start_lo, end_hi, end_lo.
    - Each value is {hi,lo} truncated to COORD_W bits.
    - On byte 3 the shadow commits to xs/xe (CASET) or ys/ye (RASET), then the state goes to IDLE.
    - A new command before byte 3 leaves the window unchanged.
  - RAMWR:
    - Phase 0 stores the high byte.
    - Phase 1 emits a pixel: pix_valid=1, pix_x/pix_y = cursor, pix_color = {hi, D}. The cursor then advances.
  - Cursor advance:
    - If x >= xe, then x=xs and y advances; otherwise x=x+1.
    - y advance: if y >= ye, then y=ys and frame_done pulses together with that pixel's pix_valid; otherwise y=y+1.
    - RAMWR continues indefinitely; the cursor wraps inside the window.
- Degenerate window: xs>xe (or ys>ye) means every pixel wraps immediately. The cursor stays at column xs (or row ys); no error is raised.
- Window change during RAMWR: impossible without a command byte, which ends RAMWR; a new 0x2C reloads the cursor.
- Reset mid-byte or mid-frame: everything returns to reset values immediately; no pulse is emitted.

Test Plan:
1. Reset, then cmd 0x11 and 0x29 -> cmd_valid pulses with cmd_code 0x11 then 0x29; sleep_out=1, disp_on=1.
2. CASET 00 0A 00 0C, RASET 00 05 00 06, RAMWR, 12 byte pairs F8 00 -> pixels (10,5),(11,5),(12,5),(10,6)..(12,6), then wrap to (10,5); pix_color=16'hF800; frame_done on the 6th and 12th pixels.
3. Latency: wr rises in cycle N on the second byte of a pair -> pix_valid high only in N+1. wr held high 5 cycles -> exactly one event.
4. RAMWR, 1 byte (AB), cmd 0x2C, bytes 12 34 -> single pixel at (xs,ys) with color 16'h1234; AB is dropped.
5. CASET 00 10 00 then cmd 0x2C -> window unchanged (xs=0, xe=239); pixel at (0,0). After 240 pixels -> pixel 241 at (0,1).
6. SWRESET after a custom window and disp_on=1 -> xs=0, xe=239, ys=0, ye=319, disp_on=0. Async nrst pulse mid-RAMWR -> outputs zero with no clk edge, and a following data byte is ignored.
